// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: N-source arbiter for a shared UART TX pin.
// A source change is only taken at a frame boundary, i.e. after the current
// source has held mark for IDLE_BITS bit periods. A source stuck low is
// overridden by a timeout instead. After every handover the pin is forced
// to mark for BLANK_BITS bit periods, so the receiver always sees a clean
// idle gap between the two sources.
module uart_tx_arbiter #(
   parameter int NUM_CH       = 2,
   parameter int BAUD_PERIOD  = 104,
   parameter int IDLE_BITS    = 11,
   parameter int BLANK_BITS   = 2,
   parameter int TIMEOUT_BITS = 64,
   parameter int RESET_SEL    = 0,
   localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] tx_in,
   input  logic [SEL_W-1:0]  sel_req,
   output logic              TXD,
   output logic [SEL_W-1:0]  active_sel,
   output logic              switch_pending,
   output logic              switch_done,
   output logic              switch_timeout
);

   // Phase lengths in clk cycles. IDLE and TIMEOUT are assumed to be at least
   // one cycle; BLANK may be zero, in which case BLANK still occupies one cycle.
   localparam int IDLE_LIM    = IDLE_BITS * BAUD_PERIOD;
   localparam int BLANK_LIM   = BLANK_BITS * BAUD_PERIOD;
   localparam int TIMEOUT_LIM = TIMEOUT_BITS * BAUD_PERIOD;
   localparam int MAX_AB      = (IDLE_LIM > BLANK_LIM) ? IDLE_LIM : BLANK_LIM;
   localparam int MAX_LIM     = (MAX_AB > TIMEOUT_LIM) ? MAX_AB : TIMEOUT_LIM;
   localparam int CNT_W       = (MAX_LIM > 1) ? $clog2(MAX_LIM + 1) : 1;
   localparam int PAD_W       = 1 << SEL_W;

   localparam logic [CNT_W-1:0] IDLE_END  = CNT_W'(IDLE_LIM - 1);
   localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(TIMEOUT_LIM - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'((BLANK_LIM == 0) ? 0 : BLANK_LIM - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   localparam logic [1:0] ST_PASS  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BLANK = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] active_sel_q, active_sel_d;
   logic [SEL_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
   logic             txd_q, txd_d;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;

   logic [PAD_W-1:0] tx_pad;
   logic             line_active;
   logic             sel_valid;
   logic [SEL_W-1:0] req_eff;
   logic             idle_hit;
   logic             wait_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Line of the currently routed source; an out-of-range request counts as
   // "stay where we are" so it can never start or retarget a switch.
   always_comb begin
      tx_pad               = '0;
      tx_pad[NUM_CH-1:0]   = tx_in;
      line_active          = tx_pad[active_sel_q];
      sel_valid            = ({1'b0, sel_req} < (SEL_W + 1)'(NUM_CH));
      req_eff              = sel_valid ? sel_req : active_sel_q;
   end

   // Next-state logic: pass-through, wait for a frame gap, then blank the line.
   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      target_d     = target_q;
      idle_cnt_d   = idle_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      blank_cnt_d  = blank_cnt_q;
      txd_d        = line_active;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      idle_hit     = 1'b0;
      wait_hit     = 1'b0;
      case (state_q)
         ST_PASS: begin
            if (req_eff != active_sel_q) begin
               target_d   = req_eff;
               idle_cnt_d = '0;
               wait_cnt_d = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (req_eff == active_sel_q) begin
               // request withdrawn: drop back without touching the pin
               state_d = ST_PASS;
            end else begin
               target_d   = req_eff;
               idle_cnt_d = line_active ? sat_inc(idle_cnt_q) : '0;
               wait_cnt_d = sat_inc(wait_cnt_q);
               idle_hit   = line_active && (idle_cnt_q >= IDLE_END);
               wait_hit   = (wait_cnt_q >= WAIT_END);
               if (idle_hit || wait_hit) begin
                  // idle completion takes precedence, so a timeout is only
                  // flagged when the gap was not seen in the same cycle
                  active_sel_d = req_eff;
                  txd_d        = 1'b1;
                  blank_cnt_d  = '0;
                  timeout_d    = !idle_hit;
                  state_d      = ST_BLANK;
               end
            end
         end
         ST_BLANK: begin
            if (blank_cnt_q >= BLANK_END) begin
               // leave blanking: pin follows the new source from this edge on
               done_d  = 1'b1;
               state_d = ST_PASS;
            end else begin
               blank_cnt_d = sat_inc(blank_cnt_q);
               txd_d       = 1'b1;
            end
         end
         default: begin
            state_d = ST_PASS;
         end
      endcase
   end

   // State registers with synchronous active-low reset; pin idles at mark.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_PASS;
         active_sel_q <= SEL_W'(RESET_SEL);
         target_q     <= SEL_W'(RESET_SEL);
         idle_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         blank_cnt_q  <= '0;
         txd_q        <= 1'b1;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_sel_q <= active_sel_d;
         target_q     <= target_d;
         idle_cnt_q   <= idle_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         blank_cnt_q  <= blank_cnt_d;
         txd_q        <= txd_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign TXD            = txd_q;
   assign active_sel     = active_sel_q;
   assign switch_pending = (state_q == ST_WAIT);
   assign switch_done    = done_q;
   assign switch_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus a randomized run, all compared
// cycle by cycle against a run-length model of the arbiter.
module tb_uart_tx_arbiter;
   localparam int NCH = 3, BP = 4, IB = 2, BB = 1, TB = 16, RS = 0;
   localparam int IDLE_LIM  = IB * BP;
   localparam int BLANK_CYC = (BB * BP == 0) ? 1 : BB * BP;
   localparam int TO_LIM    = TB * BP;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] tx_in = 3'b111;
   logic [1:0] sel_req = 2'd0;
   logic       TXD;
   logic [1:0] active_sel;
   logic       switch_pending, switch_done, switch_timeout;
   logic [5:0] obs;

   int checks = 0;
   int errors = 0;

   // model: phase 0 pass, 1 waiting for a gap, 2 blanking
   int m_phase = 0, m_sel = RS, m_target = RS, m_run = 0, m_waited = 0, m_blank_left = 0;
   bit m_txd = 1'b1, m_done = 1'b0, m_to = 1'b0;

   uart_tx_arbiter #(
      .NUM_CH(NCH), .BAUD_PERIOD(BP), .IDLE_BITS(IB), .BLANK_BITS(BB),
      .TIMEOUT_BITS(TB), .RESET_SEL(RS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tx_in(tx_in), .sel_req(sel_req),
      .TXD(TXD), .active_sel(active_sel), .switch_pending(switch_pending),
      .switch_done(switch_done), .switch_timeout(switch_timeout)
   );

   always #5 clk = ~clk;

   assign obs = {TXD, active_sel, switch_pending, switch_done, switch_timeout};

   function automatic logic [5:0] exp_vec();
      return {m_txd, 2'(m_sel), (m_phase == 1), m_done, m_to};
   endfunction

   // One clock of the arbiter rules, in terms of run lengths that include
   // the current cycle.
   task automatic model_step();
      int want;
      if (!reset_n) begin
         m_txd = 1'b1; m_sel = RS; m_phase = 0; m_done = 1'b0; m_to = 1'b0;
         m_run = 0; m_waited = 0; m_blank_left = 0;
         return;
      end
      m_done = 1'b0;
      m_to   = 1'b0;
      want   = (int'(sel_req) < NCH) ? int'(sel_req) : m_sel;
      if (m_phase == 0) begin
         m_txd = tx_in[m_sel];
         if (want != m_sel) begin
            m_target = want; m_run = 0; m_waited = 0; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_txd = tx_in[m_sel];
         if (want == m_sel) begin
            m_phase = 0;
         end else begin
            m_target = want;
            m_run    = tx_in[m_sel] ? m_run + 1 : 0;
            m_waited = m_waited + 1;
            if (m_run >= IDLE_LIM || m_waited >= TO_LIM) begin
               m_to  = (m_run < IDLE_LIM);
               m_sel = m_target;
               m_txd = 1'b1;
               m_blank_left = BLANK_CYC;
               m_phase = 2;
            end
         end
      end else begin
         m_blank_left = m_blank_left - 1;
         if (m_blank_left == 0) begin
            m_phase = 0;
            m_done  = 1'b1;
            m_txd   = tx_in[m_sel];
         end else begin
            m_txd = 1'b1;
         end
      end
   endtask

   // inputs change on the falling edge; model advances with the rising edge
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      tx_in = 3'b000; sel_req = 2'd0; reset_n = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs !== 6'b1_00_000) begin
         errors++;
         $display("FAIL reset_state got %b want %b", obs, 6'b1_00_000);
      end
      checks++;
      if (obs !== exp_vec()) begin
         errors++;
         $display("FAIL reset_model got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_clean_switch();
      int sw_at = -1, done_at = -1;
      do_reset();
      tx_in = 3'b101; sel_req = 2'd0;
      tick();
      sel_req = 2'd1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL clean_switch cyc %0d got %b want %b", i, obs, exp_vec());
         end
         if (i == 1) begin
            checks++;
            if (switch_pending !== 1'b1) begin
               errors++;
               $display("FAIL clean_pending got %b want 1", switch_pending);
            end
         end
         if (active_sel == 2'd1 && sw_at < 0) sw_at = i;
         if (switch_done === 1'b1 && done_at < 0) begin
            done_at = i;
            checks++;
            if (TXD !== 1'b0) begin
               errors++;
               $display("FAIL clean_follow_ch1 got %b want 0", TXD);
            end
         end
      end
      checks++;
      if (sw_at != 9 || done_at != 13) begin
         errors++;
         $display("FAIL clean_timing got sw %0d done %0d want sw 9 done 13", sw_at, done_at);
      end
   endtask

   task automatic test_mid_frame();
      logic [9:0] frame;
      int sw_at = -1;
      bit to_seen = 1'b0;
      frame = {1'b1, 8'h55, 1'b0};
      do_reset();
      tx_in = 3'b111; sel_req = 2'd0;
      tick(); tick();
      sel_req = 2'd1;
      for (int c = 0; c < 60; c++) begin
         tx_in[0] = (c < 40) ? frame[c / BP] : 1'b1;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL mid_frame cyc %0d got %b want %b", c, obs, exp_vec());
         end
         if (c < 40) begin
            checks++;
            if (TXD !== frame[c / BP]) begin
               errors++;
               $display("FAIL frame_bit cyc %0d got %b want %b", c, TXD, frame[c / BP]);
            end
         end
         if (switch_timeout === 1'b1) to_seen = 1'b1;
         if (active_sel == 2'd1 && sw_at < 0) sw_at = c;
      end
      checks++;
      if (sw_at != 43 || to_seen) begin
         errors++;
         $display("FAIL frame_guard got sw %0d to %0b want sw 43 to 0", sw_at, to_seen);
      end
   endtask

   task automatic test_stuck_low();
      int to_at = -1, done_at = -1;
      do_reset();
      tx_in = 3'b110; sel_req = 2'd0;
      tick();
      sel_req = 2'd2;
      for (int i = 1; i <= 80; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL stuck_low cyc %0d got %b want %b", i, obs, exp_vec());
         end
         if (switch_timeout === 1'b1 && to_at < 0) begin
            to_at = i;
            checks++;
            if (active_sel !== 2'd2 || TXD !== 1'b1) begin
               errors++;
               $display("FAIL stuck_switch got sel %0d txd %b want sel 2 txd 1", active_sel, TXD);
            end
         end
         if (switch_done === 1'b1 && done_at < 0) done_at = i;
      end
      checks++;
      if (to_at != 65 || done_at != 69) begin
         errors++;
         $display("FAIL stuck_timing got to %0d done %0d want to 65 done 69", to_at, done_at);
      end
   endtask

   task automatic test_cancel();
      int sw_at = -1;
      do_reset();
      tx_in = 3'b111; sel_req = 2'd0;
      tick();
      sel_req = 2'd1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) sel_req = 2'd0;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL cancel cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      checks++;
      if (switch_pending !== 1'b0 || active_sel !== 2'd0) begin
         errors++;
         $display("FAIL cancel_state got pend %b sel %0d want pend 0 sel 0", switch_pending, active_sel);
      end
      sel_req = 2'd1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 3) sel_req = 2'd2;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL retarget cyc %0d got %b want %b", i, obs, exp_vec());
         end
         if (active_sel != 2'd0 && sw_at < 0) sw_at = i;
      end
      checks++;
      if (sw_at != 9 || active_sel !== 2'd2) begin
         errors++;
         $display("FAIL retarget_end got sw %0d sel %0d want sw 9 sel 2", sw_at, active_sel);
      end
      sel_req = 2'd3;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL invalid_req cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      checks++;
      if (active_sel !== 2'd2 || switch_pending !== 1'b0) begin
         errors++;
         $display("FAIL invalid_ignored got sel %0d pend %b want sel 2 pend 0", active_sel, switch_pending);
      end
   endtask

   task automatic test_reset_blank();
      do_reset();
      tx_in = 3'b111; sel_req = 2'd1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL pre_blank cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      reset_n = 1'b0;
      tick();
      checks++;
      if (active_sel !== 2'd0 || TXD !== 1'b1 || switch_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_blank got sel %0d txd %b done %b want 0 1 0", active_sel, TXD, switch_done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL held_reset cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      do_reset();
      tx_in = 3'b111; sel_req = 2'd0;
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (tx_in[ch]) begin
               if ($urandom_range(0, 19) == 0) tx_in[ch] = 1'b0;
            end else begin
               if ($urandom_range(0, 2) == 0) tx_in[ch] = 1'b1;
            end
         end
         if ($urandom_range(0, 29) == 0) sel_req = 2'($urandom_range(0, 3));
         reset_n = ($urandom_range(0, 499) != 0);
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d got %b want %b", i, obs, exp_vec());
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_clean_switch();
      test_mid_frame();
      test_stuck_low();
      test_cancel();
      test_reset_blank();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
